uart_tx_module: RTL

UART transmit serializer for the UART_INTERFACE design. It sits directly downstream of the TX FIFO that the loopback/interface controller fills. It drains that FIFO one byte at a time through a single-cycle read request and shifts each byte out on the TX pin as an 8N1 frame, or 8E1 when parity is compiled in.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_bps_counter_module.sv | 49 ++++
 rtl/uart_tx_module.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART_INTERFACE TX and RX blocks:
//   - tx_state_e      : 3-bit transmit FSM state encoding (IDLE..STOP)
//   - DEF_CLK_FREQ    : default system clock frequency in Hz
//   - DEF_BAUD        : default line rate in bit/s
//   - DATA_BITS       : payload bits per frame
//   - STOP_BITS       : stop bits per frame
//   - calc_even_parity: even parity of one byte
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        LATCH  = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } tx_state_e;

    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_BAUD     = 9600;
    localparam int DATA_BITS    = 8;
    localparam int STOP_BITS    = 1;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic calc_even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_bps_counter_module.sv
// -----------------------------------------------------------------------------
// uart_bps_counter_module
// Baud-rate counter. Counts 0..BPS_CNT-1 while enabled and wraps; clear
// forces it back to 0. bit_tick pulses for one cycle when the count reaches
// the tick point: the last count of the bit (bit boundary) by default, or the
// middle of the bit when MID_TICK is set (used by the RX sampler).
//   CLK      in  system clock
//   RSTn     in  asynchronous active-low reset
//   cnt_en   in  count enable
//   cnt_clr  in  synchronous clear (wins over cnt_en)
//   bit_tick out single-cycle tick
// BPS_CNT must lie in 2..65535 so the count fits the 16-bit register.
// -----------------------------------------------------------------------------
module uart_bps_counter_module #(
    parameter int BPS_CNT  = 5208,
    parameter bit MID_TICK = 1'b0
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic cnt_en,
    input  logic cnt_clr,
    output logic bit_tick
);

    localparam logic [15:0] LAST_CNT = 16'(BPS_CNT - 1);
    localparam logic [15:0] TICK_AT  = MID_TICK ? 16'((BPS_CNT / 2) - 1) : LAST_CNT;

    logic [15:0] cnt_r;

    // Baud count register: clear, wrap at LAST_CNT, or hold.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_r <= 16'd0;
        end else if (cnt_clr) begin
            cnt_r <= 16'd0;
        end else if (cnt_en) begin
            if (cnt_r == LAST_CNT) begin
                cnt_r <= 16'd0;
            end else begin
                cnt_r <= cnt_r + 16'd1;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bit_tick = cnt_en && (cnt_r == TICK_AT);

endmodule

// File: rtl/uart_tx_module.sv
// -----------------------------------------------------------------------------
// uart_tx_module
// UART transmit serializer. Pops one byte from a non-showahead TX FIFO with a
// single-cycle read request, latches it, and shifts it out LSB first as an
// 8N1 frame (8E1 when UART_TX_PARITY_EN is defined).
//   CLK             in  system clock
//   RSTn            in  asynchronous active-low reset
//   Empty_Sig       in  TX FIFO empty flag (only looked at in IDLE)
//   FIFO_Read_Data  in  TX FIFO q, valid the cycle after Read_Req_Sig
//   Read_Req_Sig    out FIFO read request, one pulse per byte
//   TX_Pin_Out      out serial line, idle high
//   Busy_Sig        out high from the read request until the stop bit ends
// Configuration macro: UART_TX_PARITY_EN adds an even parity bit.
// All outputs are registers loaded from the next-state decode, so each
// output already shows the value that belongs to the state being entered.
// -----------------------------------------------------------------------------
module uart_tx_module
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Empty_Sig,
    input  logic [7:0] FIFO_Read_Data,
    output logic       Read_Req_Sig,
    output logic       TX_Pin_Out,
    output logic       Busy_Sig
);

    localparam int         BPS_CNT  = CLK_FREQ / BAUD;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e  state_r;
    tx_state_e  state_nxt_s;
    logic [2:0] bit_idx_r;
    logic [2:0] bit_idx_nxt_s;
    logic [7:0] shift_r;
    logic [7:0] shift_nxt_s;
    logic       tx_r;
    logic       tx_nxt_s;
    logic       req_r;
    logic       busy_r;
    logic       cnt_en_s;
    logic       bit_tick_s;

    // The baud counter runs only while a bit is on the line; it is held at 0
    // through LATCH so that START always begins with a fresh count.
    assign cnt_en_s = (state_r == START) || (state_r == DATA) ||
                      (state_r == PARITY) || (state_r == STOP);

    uart_bps_counter_module #(
        .BPS_CNT  (BPS_CNT),
        .MID_TICK (1'b0)
    ) u_bps (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .cnt_en   (cnt_en_s),
        .cnt_clr  (!cnt_en_s),
        .bit_tick (bit_tick_s)
    );

`ifdef UART_TX_PARITY_EN
    logic parity_r;

    // Parity is taken from the byte as it is latched, not from live FIFO data.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            parity_r <= 1'b0;
        end else if (state_r == LATCH) begin
            parity_r <= calc_even_parity(FIFO_Read_Data);
        end else begin
            parity_r <= parity_r;
        end
    end
`endif

    // Next-state, next shift contents and next line level.
    always_comb begin
        state_nxt_s   = state_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        tx_nxt_s      = 1'b1;
        case (state_r)
            IDLE: begin
                if (!Empty_Sig) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                state_nxt_s = LATCH;
            end
            LATCH: begin
                shift_nxt_s   = FIFO_Read_Data;
                bit_idx_nxt_s = 3'd0;
                state_nxt_s   = START;
                tx_nxt_s      = 1'b0;
            end
            START: begin
                if (bit_tick_s) begin
                    state_nxt_s = DATA;
                    tx_nxt_s    = shift_r[0];
                end else begin
                    tx_nxt_s    = 1'b0;
                end
            end
            DATA: begin
                if (!bit_tick_s) begin
                    tx_nxt_s = shift_r[0];
                end else if (bit_idx_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt_s = PARITY;
                    tx_nxt_s    = parity_r;
`else
                    state_nxt_s = STOP;
                    tx_nxt_s    = 1'b1;
`endif
                end else begin
                    bit_idx_nxt_s = bit_idx_r + 3'd1;
                    shift_nxt_s   = {1'b0, shift_r[7:1]};
                    tx_nxt_s      = shift_r[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick_s) begin
                    state_nxt_s = STOP;
                    tx_nxt_s    = 1'b1;
                end else begin
                    tx_nxt_s    = parity_r;
                end
            end
`endif
            STOP: begin
                if (bit_tick_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r   <= IDLE;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
            req_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
            tx_r      <= tx_nxt_s;
            req_r     <= (state_nxt_s == REQ);
            busy_r    <= (state_nxt_s != IDLE);
        end
    end

    assign TX_Pin_Out   = tx_r;
    assign Read_Req_Sig = req_r;
    assign Busy_Sig     = busy_r;

endmodule
